// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR controller: FSM state encoding,
// tap/history counts and the drain/flush counter sizing helper.
package fir_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_UNCFG = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_LOAD  = 3'd3,
    ST_FLUSH = 3'd4
  } state_t;

  localparam int TAPS = 4;
  localparam int HIST = 2;

  // The counter must hold both the drain length and the flush length.
  function automatic int cnt_width(input int latency);
    int m;
    m = (latency > HIST) ? latency : HIST;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/fir_valid_pipe.sv
// Shift register of accept flags that retires one m_valid per accepted
// sample, DEPTH edges after the flag enters.
module fir_valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_acc,
  output logic o_valid,
  output logic o_empty
);

  logic [DEPTH-1:0] r_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_acc;
      for (int i = 1; i < DEPTH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_valid = r_pipe[DEPTH-1];
  assign o_empty = ~|r_pipe;

endmodule

// File: rtl/fir_ctrl.sv
// Sequencer for the 4-tap MAC datapath: shadow/active coefficient banks,
// gated sample stream, drain/load/flush around commits, aligned output valid.
module fir_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [1:0]           cfg_addr,
  input  logic [WIDTH-1:0]     cfg_data,
  input  logic                 cfg_commit,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WIDTH-1:0]     s_data,
  output logic [WIDTH-1:0]     fir_data_in,
  output logic [WIDTH-1:0]     fir_c1,
  output logic [WIDTH-1:0]     fir_c2,
  output logic [WIDTH-1:0]     fir_c3,
  output logic [WIDTH-1:0]     fir_c4,
  input  logic [2*WIDTH+1:0]   fir_sum,
  output logic                 m_valid,
  output logic [2*WIDTH+1:0]   m_data,
  output logic                 busy
);

  localparam int CNT_W = cnt_width(LATENCY);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(HIST - 1);

  state_t                      r_state;
  state_t                      w_next;
  logic [CNT_W-1:0]            r_cnt;
  logic [TAPS-1:0][WIDTH-1:0]  r_shadow;
  logic [TAPS-1:0][WIDTH-1:0]  r_active;
  logic [WIDTH-1:0]            r_data;
  logic                        r_acc;
  logic                        w_cnt_done;
  logic                        w_pipe_empty;
  logic                        w_retired;
  logic                        w_cfg_ready;
  logic                        w_load;
  logic                        w_accept;
  logic                        w_cfg_we;

  assign w_cnt_done = (r_cnt == '0);
  assign w_retired  = w_pipe_empty & ~r_acc;
  assign w_accept   = s_valid & s_ready;
  assign cfg_ready  = w_cfg_ready & rst_n;
  assign w_cfg_we   = cfg_valid & cfg_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_UNCFG;
    end else begin
      r_state <= w_next;
    end
  end

  // Commits outside UNCFG/RUN are dropped; the host polls busy instead.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_UNCFG: if (cfg_commit) w_next = ST_LOAD;
      ST_RUN:   if (cfg_commit) w_next = ST_DRAIN;
      ST_DRAIN: if (w_cnt_done) w_next = ST_LOAD;
      ST_LOAD:  w_next = ST_FLUSH;
      ST_FLUSH: if (w_cnt_done && w_retired) w_next = ST_RUN;
      default:  w_next = ST_UNCFG;
    endcase
  end

  always_comb begin
    s_ready     = 1'b0;
    w_cfg_ready = 1'b0;
    busy        = 1'b0;
    w_load      = 1'b0;
    unique case (r_state)
      ST_UNCFG: w_cfg_ready = 1'b1;
      ST_RUN: begin
        s_ready     = 1'b1;
        w_cfg_ready = 1'b1;
      end
      ST_DRAIN: busy = 1'b1;
      ST_LOAD: begin
        busy   = 1'b1;
        w_load = 1'b1;
      end
      ST_FLUSH: busy = 1'b1;
      default: ;
    endcase
  end

  // Loaded on entry to DRAIN/FLUSH, counts down to the last cycle of the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      if (w_next == ST_DRAIN)      r_cnt <= DRAIN_LAST;
      else if (w_next == ST_FLUSH) r_cnt <= FLUSH_LAST;
      else                         r_cnt <= '0;
    end else if (!w_cnt_done) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      if (w_cfg_we) r_shadow[cfg_addr] <= cfg_data;
      if (w_load)   r_active <= r_shadow;
    end
  end

  // Cycles without an accepted sample feed zeros into the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_acc  <= 1'b0;
    end else begin
      r_data <= w_accept ? s_data : '0;
      r_acc  <= w_accept;
    end
  end

  fir_valid_pipe #(
    .DEPTH (LATENCY)
  ) u_valid_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_acc   (r_acc),
    .o_valid (m_valid),
    .o_empty (w_pipe_empty)
  );

  assign fir_data_in = r_data;
  assign fir_c1      = r_active[0];
  assign fir_c2      = r_active[1];
  assign fir_c3      = r_active[2];
  assign fir_c4      = r_active[3];
  assign m_data      = fir_sum;

endmodule
